seq_mul_responder: RTL
======================

# seq_mul_responder

Multi-cycle shift-add multiplier that serves multiply requests from the FACTORIAL sequencer and other iterative controllers. The requester drives two operands and a request; this block runs a fixed-latency radix-2 multiply, then returns the truncated product, an overflow flag and a one-cycle acknowledge. It replaces the single-cycle ALU multiply path so iterative operations can close timing at higher clock rates.

## Interface
- WIDTH, 16, operand and result width in bits (≥2)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  1  request, level-sensitive; accepted only when busy=0
- a  input  WIDTH  multiplicand (running product from requester)
- b  input  WIDTH  multiplier (current iteration value)
- busy  output  1  high from the accept edge until the return to IDLE
- ack  output  1  one-cycle pulse; res/ovf valid while high
- res  output  WIDTH  low WIDTH bits of a*b, held until the next completion
- ovf  output  1  high if any bit of the full 2*WIDTH-bit product above WIDTH-1 is set

## Operation
- Unsigned arithmetic only. Internal state: acc (2*WIDTH), mcand (2*WIDTH, shifted left), mplier (WIDTH, shifted right), cnt (clog2(WIDTH+1) bits).
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, ack=0. If req=1 on an edge: mcand ← zero-extended a, mplier ← b, acc ← 0, cnt ← 0, go to RUN.
- RUN: busy=1. Each edge: if mplier[0], acc ← acc + mcand; mcand ← mcand<<1; mplier ← mplier>>1; cnt ← cnt+1. On the edge where cnt=WIDTH-1 (the WIDTH-th iteration), the final sum is computed; res ← final acc[WIDTH-1:0], ovf ← |final acc[2*WIDTH-1:WIDTH], go to DONE.
- No early termination. Latency is fixed and independent of the operand values.
- DONE: busy=1, ack=1 for exactly one cycle; next edge goes to IDLE.
- req while RUN or DONE is ignored; there is no queueing. Operands are captured only at the accept edge. Changing a/b afterwards has no effect.
- With req held high continuously, the next operation is accepted on the first edge in IDLE, one cycle after ack falls.
- res/ovf change only on entry to DONE. Between operations they hold the last result.
- Reset (any time, including mid-RUN or in DONE): state IDLE, busy=0, ack=0, res=0, ovf=0, acc/mcand/mplier/cnt=0. An aborted operation never produces ack.

## Timing
- Accept edge k (IDLE, req=1): busy rises after edge k.
- Iterations occur on edges k+1 … k+WIDTH. DONE is entered at edge k+WIDTH, where res/ovf update and ack rises.
- ack falls and busy falls at edge k+WIDTH+1, returning to IDLE.
- Earliest next accept is edge k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles. For WIDTH=16 that is a 16-cycle request-to-ack latency and an 18-cycle period.
- ack, busy and res are all registered state or state decodes. There is no combinational path from req, a or b to any output.
- Requester contract: sample res on the cycle ack=1. Deassert req or present new operands no later than the ack cycle if back-to-back repeat is not intended.

## Test plan
- Factorial chain, WIDTH=16: a=1,b=5 → ack at edge 16 after accept, res=5. Then a=5,b=4 → res=20. Then a=20,b=3 → res=60. Then a=60,b=2 → res=120. All with ovf=0 and busy low for exactly 1 cycle between operations.
- Boundary values: a=0,b=0xFFFF → res=0, ovf=0. a=0x00FF,b=0x0101 → res=0xFFFF, ovf=0. a=0x0100,b=0x0100 → res=0x0000, ovf=1. a=0xFFFF,b=0xFFFF → res=0x0001, ovf=1.
- Busy rejection: accept a=3,b=7, then pulse req with a=9,b=9 on cycles 5 and 16 after accept → single ack, res=21. No second operation starts unless req is high in IDLE.
- Held req: req=1 constant with a=2,b=3 → ack pulses every 18 cycles, res=6 each time. ack is never high for 2 consecutive cycles.
- Reset mid-operation: accept a=7,b=7, assert rst 8 cycles later for 1 cycle → busy=0, ack=0, res=0, ovf=0 immediately on rst (asynchronous). No ack follows. A new request for a=7,b=7 then yields res=49 with normal latency.
- Operand stability: accept a=6,b=6, change a/b to 0xFFFF on the following cycle → res=36, ovf=0.

Source files
------------

// File: rtl/seq_mul_responder_if.sv
// seq_mul_responder_if: request/acknowledge bundle between an iterative
// controller (master) and the shift-add multiplier (slave).
interface seq_mul_responder_if #(
   parameter int WIDTH = 16
);
   logic             req;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             ack;
   logic [WIDTH-1:0] res;
   logic             ovf;

   modport master (
      output req, a, b,
      input  busy, ack, res, ovf
   );

   modport slave (
      input  req, a, b,
      output busy, ack, res, ovf
   );
endinterface

// File: rtl/seq_mul_responder.sv
// seq_mul_responder: fixed-latency radix-2 shift-add multiplier.
// Returns the truncated product, an overflow flag and a one-cycle ack.
module seq_mul_responder #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_mul_responder_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              ovf_q, ovf_d;
   logic [PW-1:0]     acc_sum;

   // Next state: capture operands in IDLE, iterate in RUN, pulse ack in DONE.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      ovf_d    = ovf_q;
      acc_sum  = mplier_q[0] ? acc_q + mcand_q : acc_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               mcand_d  = {{WIDTH{1'b0}}, bus.a};
               mplier_d = bus.b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               res_d   = acc_sum[WIDTH-1:0];
               ovf_d   = |acc_sum[PW-1:WIDTH];
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.ack  = (state_q == DONE);
   assign bus.res  = res_q;
   assign bus.ovf  = ovf_q;
endmodule
